bus_decoder_n: RTL
==================

Name: bus_decoder_n

Overview:
- Parametrised single-master, N-slave memory-mapped bus decoder/sequencer between the riscv core and its peripherals (SRAM, GPIO/display, UART, …).
- Each slave owns a region selected by a fixed address tag.
- Each slave answers with its own ready, so per-slave wait states are supported.
- Master side keeps the core's valid/ready four-phase handshake; unmapped accesses and slave timeouts are terminated with an error response instead of hanging the core.

Parameters:
- NSLAVES, 4, number of slave channels (1..8)
- DATA_W, 32, data bus width (multiple of 8)
- TAG_HI, 31, MSB of address decode field
- TAG_LO, 20, LSB of address decode field
- TAG_W, TAG_HI-TAG_LO+1, derived tag width
- TAGS, {12'h300,12'h200,12'h100,12'h000}, packed NSLAVES*TAG_W; slave i tag = TAGS[i*TAG_W +: TAG_W]
- TIMEOUT, 255, max cycles waiting for s_ready; 0 disables timeout
- ERR_DATA, 32'hDEADBEEF, read data returned on error

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- m_addr  in  32  master address
- m_wdata  in  DATA_W  master write data
- m_lane  in  DATA_W/8  byte enables
- m_wr  in  1  1=write, 0=read
- m_valid  in  1  request; held until m_ready seen
- m_rdata  out  DATA_W  read data, registered
- m_ready  out  1  completion, held while m_valid stays high
- s_sel  out  NSLAVES  one-hot slave select
- s_addr  out  32  registered copy of m_addr
- s_wdata  out  DATA_W  registered write data
- s_lane  out  DATA_W/8  registered byte enables
- s_wr  out  1  registered write flag
- s_rdata  in  NSLAVES*DATA_W  slave read data; slave i at [i*DATA_W +: DATA_W]
- s_ready  in  NSLAVES  slave completion, level or pulse
- err  out  1  one-cycle pulse on error termination
- err_addr  out  32  address of last errored access

Behaviour:
- Reset: sampled on rising clk while rst_n=0. It overrides everything, including mid-transfer. Outputs on the following edge: m_ready=0, m_rdata=0, s_sel=0, s_addr/s_wdata/s_lane/s_wr=0, err=0, err_addr=0. State=IDLE, timeout counter=0.
- States: IDLE, ACCESS, RESP.
- IDLE, m_valid=1:
  - Latch addr/wdata/lane/wr into s_* registers.
  - Decode tag = m_addr[TAG_HI:TAG_LO]; the lowest index i with tag==TAGS[i] wins.
  - Hit: s_sel[i]<=1, counter<=0, go to ACCESS.
  - Miss: m_rdata<=ERR_DATA (reads only; writes leave m_rdata unchanged), m_ready<=1, err<=1, err_addr<=m_addr, go to RESP.
- ACCESS:
  - On a cycle where s_ready[i]=1 for the selected i: s_sel<=0; if read, m_rdata<=s_rdata[i]; m_ready<=1; go to RESP.
  - Otherwise the counter increments. When TIMEOUT!=0 and the counter reaches TIMEOUT without s_ready: s_sel<=0, m_rdata<=ERR_DATA (reads), m_ready<=1, err<=1, err_addr<=s_addr, go to RESP.
  - s_ready on non-selected channels is ignored.
  - s_ready and the timeout in the same cycle: s_ready wins, no error.
- RESP:
  - m_ready<=m_valid each cycle.
  - When m_valid=0 is sampled, go to IDLE; m_ready is 0 from the next edge.
  - A new request is not accepted until IDLE, so back-to-back accesses need at least one m_valid-low cycle.
- err is a single-cycle pulse and is cleared the cycle after it is set.
- Latency, hit with slave ready on its first ACCESS cycle: m_ready high on the 2nd edge after m_valid is sampled. Unmapped access: 1 edge.
- s_sel is one-hot or zero, never multi-hot. s_* address/data are stable for the whole time s_sel is high.
- m_valid dropping during ACCESS is a protocol violation: the transfer still completes to RESP, then returns to IDLE.
- Write accesses never modify m_rdata.

Test Plan:
- Reset: hold rst_n=0 for 3 clk with m_valid=1 -> all outputs 0, no s_sel; release -> request accepted next edge.
- Read slave 1 (m_addr=32'h1000_0004), s_ready[1] pulses on the 3rd ACCESS cycle with s_rdata slice=32'h1234_5678 -> s_sel=4'b0010 for exactly 3 cycles, m_rdata=32'h1234_5678, m_ready held high until m_valid drops, then low next edge.
- Write slave 0 (32'h0000_0010, wdata 32'hA5A5_0F0F, lane 4'b0011) with s_ready tied high -> s_wr=1, s_lane=4'b0011, s_sel=4'b0001 for 1 cycle, m_rdata unchanged, err=0.
- Unmapped read (32'h7000_0000) -> m_ready after 1 edge, m_rdata=32'hDEADBEEF, err pulses once, err_addr=32'h7000_0000, s_sel stays 0.
- Timeout: TIMEOUT=4, read slave 2 with s_ready[2]=0 -> s_sel[2] high for 4 cycles, then m_rdata=ERR_DATA, err pulse, err_addr=32'h2000_0000; repeat with s_ready[2] rising on the terminal cycle -> slave data returned, no err.
- Reset mid-ACCESS: assert rst_n=0 while s_sel[3]=1 -> next edge s_sel=0, m_ready=0; a late s_ready[3] after reset is ignored.

Source files
------------

// File: rtl/bus_decoder_n.sv
//------------------------------------------------------------------------------
// Module   : bus_decoder_n
// Brief    : Single-master, N-slave tag-decoded bus sequencer with timeout/error.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module bus_decoder_n #(
    parameter int                          NSLAVES  = 4,
    parameter int                          DATA_W   = 32,
    parameter int                          TAG_HI   = 31,
    parameter int                          TAG_LO   = 20,
    parameter int                          TAG_W    = TAG_HI - TAG_LO + 1,
    parameter logic [NSLAVES*TAG_W-1:0]    TAGS     = {12'h300, 12'h200, 12'h100, 12'h000},
    parameter int                          TIMEOUT  = 255,
    parameter logic [DATA_W-1:0]           ERR_DATA = 32'hDEADBEEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [31:0]            m_addr,
    input  logic [DATA_W-1:0]      m_wdata,
    input  logic [DATA_W/8-1:0]    m_lane,
    input  logic                   m_wr,
    input  logic                   m_valid,
    output logic [DATA_W-1:0]      m_rdata,
    output logic                   m_ready,
    output logic [NSLAVES-1:0]     s_sel,
    output logic [31:0]            s_addr,
    output logic [DATA_W-1:0]      s_wdata,
    output logic [DATA_W/8-1:0]    s_lane,
    output logic                   s_wr,
    input  logic [NSLAVES*DATA_W-1:0] s_rdata,
    input  logic [NSLAVES-1:0]     s_ready,
    output logic                   err,
    output logic [31:0]            err_addr
);

    // Counter only needs to reach TIMEOUT-1: the terminal ACCESS cycle is the one it equals that.
    localparam int              CNT_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t                 r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [DATA_W-1:0]      r_rdata;
    logic                   r_m_ready;
    logic [NSLAVES-1:0]     r_sel;
    logic [31:0]            r_addr;
    logic [DATA_W-1:0]      r_wdata;
    logic [DATA_W/8-1:0]    r_lane;
    logic                   r_wr;
    logic                   r_err;
    logic [31:0]            r_err_addr;

    logic [TAG_W-1:0]       w_tag;
    logic [NSLAVES-1:0]     w_hit_oh;
    logic                   w_sel_rdy;
    logic [DATA_W-1:0]      w_sel_rdata;

    always_comb begin
        w_tag       = m_addr[TAG_HI:TAG_LO];
        w_hit_oh    = '0;
        w_sel_rdata = '0;
        // Scan downward so the lowest matching index is the final assignment.
        for (int i = NSLAVES - 1; i >= 0; i--) begin
            if (w_tag == TAGS[i*TAG_W +: TAG_W]) begin
                w_hit_oh = NSLAVES'(1) << i;
            end
        end
        for (int i = 0; i < NSLAVES; i++) begin
            if (r_sel[i]) begin
                w_sel_rdata = w_sel_rdata | s_rdata[i*DATA_W +: DATA_W];
            end
        end
        w_sel_rdy = |(s_ready & r_sel);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_rdata    <= '0;
            r_m_ready  <= 1'b0;
            r_sel      <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_lane     <= '0;
            r_wr       <= 1'b0;
            r_err      <= 1'b0;
            r_err_addr <= '0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_m_ready <= 1'b0;
                    if (m_valid) begin
                        r_addr  <= m_addr;
                        r_wdata <= m_wdata;
                        r_lane  <= m_lane;
                        r_wr    <= m_wr;
                        if (|w_hit_oh) begin
                            r_sel   <= w_hit_oh;
                            r_cnt   <= '0;
                            r_state <= ST_ACCESS;
                        end else begin
                            if (!m_wr) begin
                                r_rdata <= ERR_DATA;
                            end
                            r_m_ready  <= 1'b1;
                            r_err      <= 1'b1;
                            r_err_addr <= m_addr;
                            r_state    <= ST_RESP;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (w_sel_rdy) begin
                        r_sel <= '0;
                        if (!r_wr) begin
                            r_rdata <= w_sel_rdata;
                        end
                        r_m_ready <= 1'b1;
                        r_state   <= ST_RESP;
                    end else if ((TIMEOUT != 0) && (r_cnt == c_CNT_LAST)) begin
                        r_sel <= '0;
                        if (!r_wr) begin
                            r_rdata <= ERR_DATA;
                        end
                        r_m_ready  <= 1'b1;
                        r_err      <= 1'b1;
                        r_err_addr <= r_addr;
                        r_state    <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    r_m_ready <= m_valid;
                    if (!m_valid) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign m_rdata  = r_rdata;
    assign m_ready  = r_m_ready;
    assign s_sel    = r_sel;
    assign s_addr   = r_addr;
    assign s_wdata  = r_wdata;
    assign s_lane   = r_lane;
    assign s_wr     = r_wr;
    assign err      = r_err;
    assign err_addr = r_err_addr;

endmodule

`default_nettype wire
